// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared widths and types for the I/D cache memory arbiter.
// Provides LINE_W/ADDR_W, the line and word types, the arbiter state and the owner encoding.
package cache_arbiter_pkg;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;
    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [ADDR_W-1:0] lc3b_word;
    typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
    typedef enum logic {OWNER_I, OWNER_D} arb_owner_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: bundle of the I-cache, D-cache and physical-memory ports of the arbiter.
// slave  : arbiter view (takes cache requests and pmem replies, drives pmem commands and cache replies).
// master : environment view (caches and physical memory), the mirror image of slave.
interface cache_arbiter_if;
    import cache_arbiter_pkg::*;
    logic     i_mem_read;
    lc3b_word i_mem_address;
    lc3b_line i_mem_rdata;
    logic     i_mem_resp;
    logic     d_mem_read;
    logic     d_mem_write;
    lc3b_word d_mem_address;
    lc3b_line d_mem_wdata;
    lc3b_line d_mem_rdata;
    logic     d_mem_resp;
    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;
    modport slave (
        input  i_mem_read, i_mem_address, d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
               pmem_rdata, pmem_resp,
        output i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
    modport master (
        output i_mem_read, i_mem_address, d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
               pmem_rdata, pmem_resp,
        input  i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one physical-memory port between the I-cache and D-cache miss paths.
// Ports: clk, rst_n (async, active-low), bus (cache_arbiter_if.slave: I/D cache requests and replies, pmem command/reply).
// One line transaction is latched at grant and forwarded until pmem_resp; the reply is routed to the owner only.
module cache_arbiter
    import cache_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    cache_arbiter_if.slave bus
);
    arb_state_t state_q, state_d;
    arb_owner_t last_grant_q, last_grant_d;
    logic       op_write_q, op_write_d;
    lc3b_word   addr_q, addr_d;
    lc3b_line   wdata_q, wdata_d;
    logic       i_req, d_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= OWNER_I;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        i_req            = bus.i_mem_read;
        d_req            = bus.d_mem_read | bus.d_mem_write;
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        op_write_d       = op_write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = (state_q == ARB_IDLE) ? '0 : addr_q;
        bus.pmem_wdata   = (state_q == ARB_IDLE) ? '0 : wdata_q;
        bus.i_mem_rdata  = bus.pmem_rdata;
        bus.d_mem_rdata  = bus.pmem_rdata;
        bus.i_mem_resp   = 1'b0;
        bus.d_mem_resp   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // On a tie D wins unless it was granted last, so grants alternate under contention.
                if (d_req && (!i_req || last_grant_q == OWNER_I)) begin
                    state_d      = ARB_SERVE_D;
                    last_grant_d = OWNER_D;
                    op_write_d   = bus.d_mem_write;
                    addr_d       = bus.d_mem_address;
                    wdata_d      = bus.d_mem_wdata;
                end else if (i_req) begin
                    state_d      = ARB_SERVE_I;
                    last_grant_d = OWNER_I;
                    op_write_d   = 1'b0;
                    addr_d       = bus.i_mem_address;
                end
            end
            ARB_SERVE_I: begin
                bus.pmem_read  = 1'b1;
                bus.i_mem_resp = bus.pmem_resp;
                state_d        = bus.pmem_resp ? ARB_IDLE : state_q;
            end
            ARB_SERVE_D: begin
                bus.pmem_read  = !op_write_q;
                bus.pmem_write = op_write_q;
                bus.d_mem_resp = bus.pmem_resp;
                state_d        = bus.pmem_resp ? ARB_IDLE : state_q;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Read and write together from the D-cache is illegal; the write is taken above.
    assert property (@(posedge clk) disable iff (!rst_n) !(bus.d_mem_read && bus.d_mem_write))
        else $error("cache_arbiter: d_mem_read and d_mem_write both high");
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction-cache miss path (IF stage) and the data-cache miss path (MEM stage) of the pipelined LC-3b. Requests are arbitrated round-robin, and each granted transaction is latched. The block forwards one line-sized read or write at a time and routes the response back to the owner. It sits between the two L1 caches and physical memory (or L2).

## Interface
- LINE_W, 128, width of one cache line / memory transfer in bits
- ADDR_W, 16, address width (matches lc3b_word)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_mem_read  in  1  I-cache line read request, level-held until i_mem_resp
- i_mem_address  in  ADDR_W  I-cache line address
- i_mem_rdata  out  LINE_W  read data to I-cache
- i_mem_resp  out  1  one-cycle completion pulse to I-cache
- d_mem_read  in  1  D-cache line read request, level-held
- d_mem_write  in  1  D-cache line write request (writeback), level-held
- d_mem_address  in  ADDR_W  D-cache line address
- d_mem_wdata  in  LINE_W  D-cache write data
- d_mem_rdata  out  LINE_W  read data to D-cache
- d_mem_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read / pmem_write  out  1 each  physical memory command, held until pmem_resp
- pmem_address  out  ADDR_W  physical memory address
- pmem_wdata  out  LINE_W  physical memory write data
- pmem_rdata  in  LINE_W  physical memory read data
- pmem_resp  in  1  physical memory completion, valid for one cycle

## Operation
- States:
  - IDLE: no command driven; arbitration happens here.
  - SERVE_I: serving the I-cache read.
  - SERVE_D: serving the D-cache read or write.
- Request terms: i_req = i_mem_read; d_req = d_mem_read | d_mem_write.
- IDLE transitions:
  - only i_req → SERVE_I.
  - only d_req → SERVE_D.
  - both → the requester not granted last (last_grant register).
  - none → stay in IDLE.
- On the IDLE→SERVE edge, latch into registers: op (read/write), address, wdata (D only), and update last_grant.
- In SERVE_x, pmem_read/pmem_write/pmem_address/pmem_wdata come only from the latched registers. Requester inputs are ignored until the next IDLE.
- SERVE_x with pmem_resp=1 → assert x_mem_resp combinationally that cycle, then return to IDLE. Always return to IDLE, even if the other requester is pending.
- SERVE_x with pmem_resp=0 → hold state and all pmem outputs.
- i_mem_rdata and d_mem_rdata both carry pmem_rdata unconditionally; only the resp pulse qualifies them.
- The non-owner's resp is never asserted. pmem_resp seen in IDLE is ignored.
- d_mem_read and d_mem_write both high is illegal. The write wins, and a simulation assertion fires.

## Timing
- Reset values: state=IDLE, last_grant=I (so D wins the first tie), pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_mem_resp=d_mem_resp=0.
- Latency:
  - request seen in IDLE at cycle n → pmem command asserted at n+1.
  - pmem_resp at cycle m → requester resp at m (zero added latency on return).
  - back in IDLE at m+1; next grant drives pmem at m+2.
- pmem_read/pmem_write are low for at least one cycle between transactions, which lets the served cache drop its request.
- The served requester still shows its request in the resp cycle. The arbiter does not re-grant it because the state is not IDLE.
- Reset asserted mid-transaction: the block goes to IDLE asynchronously and pmem commands drop immediately. The outstanding transaction is abandoned; physical memory must be reset together with the arbiter.
- No starvation: with both requesters continuously pending, grants strictly alternate.

## Structure
- Add to lc3b_types:
  - typedef lc3b_line (logic [127:0]).
  - enum arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
  - enum arb_owner_t {OWNER_I, OWNER_D}.
- Single module with no sub-modules:
  - one always_ff for state, last_grant and the latched op/address/wdata.
  - one always_comb for next state, pmem outputs and resp routing.

## Test plan
- I read alone: i_mem_read=1, addr 0x1230, pmem_resp after 3 cycles with rdata 0xAAAA…:
  - pmem_read high from cycle 1 with address 0x1230.
  - i_mem_resp pulses once with that data.
  - d_mem_resp stays 0.
- D write alone: d_mem_write=1, addr 0x4000, wdata 0x1234…5678:
  - pmem_write=1 with the exact address and wdata.
  - d_mem_resp pulses on pmem_resp.
  - pmem_write low the next cycle.
- Simultaneous requests after reset:
  - D is granted first, then I.
  - With both held asserted, the grant order is D, I, D, I…
  - There is always one idle cycle between transactions.
- Requester inputs change during SERVE_D (d_mem_address 0x4000→0x5000 while waiting): pmem_address stays 0x4000 until pmem_resp.
- rst_n asserted mid-SERVE_I:
  - pmem_read drops without waiting for a clock edge.
  - After release, state is IDLE and a new D request is granted normally.
- Spurious pmem_resp in IDLE → no resp to either cache and no state change.
